// File: rtl/prio_irq_ctrl_if.sv
// Request/grant bundle between interrupt sources, the priority controller and its sequencer.
interface prio_irq_ctrl_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = $clog2(N);

    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         valid;
    logic [W-1:0] id;
    logic [N-1:0] pending;

    modport master (output en, req, mask, ack, input valid, id, pending);
    modport slave  (input en, req, mask, ack, output valid, id, pending);
endinterface

// File: rtl/prio_irq_ctrl.sv
// Registered priority interrupt controller: edge-captured pending bits, per-line mask,
// fixed or round-robin selection, valid/ack grant handshake.
module prio_irq_ctrl #(
    parameter int unsigned N  = 8,
    parameter bit          RR = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    prio_irq_ctrl_if.slave bus
);
    localparam int unsigned W = $clog2(N);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state_q;
    logic [N-1:0] req_q;
    logic [N-1:0] pending_q;
    logic [W-1:0] id_q;
    logic [W-1:0] last_q;
    logic         valid_q;

    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] pending_d;
    logic [N-1:0] eligible;
    logic [W-1:0] sel_fixed;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;
    int unsigned  rr_idx;

    assign rise     = bus.req & ~req_q;
    assign eligible = pending_q & ~bus.mask;

    // Rise is OR-ed in after the clear so a same-cycle new edge survives the ack.
    always_comb begin
        clr = '0;
        if (state_q == GRANT && bus.ack) begin
            clr[id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    // Later loop hits override earlier ones, so the last match is the highest priority.
    always_comb begin
        sel_fixed = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i]) sel_fixed = W'(i);
        end
        sel_rr = '0;
        rr_idx = 0;
        for (int unsigned off = N; off >= 1; off--) begin
            rr_idx = (32'(last_q) + N - off) % N;
            if (eligible[W'(rr_idx)]) sel_rr = W'(rr_idx);
        end
        sel = RR ? sel_rr : sel_fixed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            id_q      <= '0;
            last_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            req_q     <= bus.req;
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (bus.en && (eligible != '0)) begin
                        state_q <= GRANT;
                        id_q    <= sel;
                        valid_q <= 1'b1;
                    end
                end
                GRANT: begin
                    // id stays frozen until the sequencer accepts it.
                    if (bus.ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        if (RR) last_q <= id_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid   = valid_q;
    assign bus.id      = id_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Drives a fixed-priority and a round-robin controller with identical stimulus and
// compares both against per-cycle expectations queued as each vector is applied.
module tb_prio_irq_ctrl;
    localparam int unsigned N = 8;

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       en;
        logic       ack;
        logic       v0;
        logic [2:0] id0;
        logic [7:0] p0;
        logic       v1;
        logic [2:0] id1;
        logic [7:0] p1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    vec_t exp_q[$];
    vec_t e;

    prio_irq_ctrl_if #(.N(N)) bus0 ();
    prio_irq_ctrl_if #(.N(N)) bus1 ();

    assign bus0.en = en;  assign bus0.req = req;  assign bus0.mask = mask;  assign bus0.ack = ack;
    assign bus1.en = en;  assign bus1.req = req;  assign bus1.mask = mask;  assign bus1.ack = ack;

    prio_irq_ctrl #(.N(N), .RR(1'b0)) dut_fix (.clk(clk), .rst(rst), .bus(bus0));
    prio_irq_ctrl #(.N(N), .RR(1'b1)) dut_rr  (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v0, input logic [2:0] id0,
                           input logic [7:0] p0, input logic v1, input logic [2:0] id1,
                           input logic [7:0] p1);
        chk({tag, " fix valid"}, 64'(bus0.valid), 64'(v0));
        if (v0) chk({tag, " fix id"}, 64'(bus0.id), 64'(id0));
        chk({tag, " fix pending"}, 64'(bus0.pending), 64'(p0));
        chk({tag, " rr valid"}, 64'(bus1.valid), 64'(v1));
        if (v1) chk({tag, " rr id"}, 64'(bus1.id), 64'(id1));
        chk({tag, " rr pending"}, 64'(bus1.pending), 64'(p1));
    endtask

    task automatic add(input logic [7:0] rq, input logic [7:0] mk, input logic e_n,
                       input logic ak, input logic v0, input logic [2:0] id0,
                       input logic [7:0] p0, input logic v1, input logic [2:0] id1,
                       input logic [7:0] p1);
        vec_t v;
        v.req = rq; v.mask = mk; v.en = e_n; v.ack = ak;
        v.v0 = v0; v.id0 = id0; v.p0 = p0;
        v.v1 = v1; v.id1 = id1; v.p1 = p1;
        tbl.push_back(v);
    endtask

    initial begin
        // fixed priority: 5 then 1
        add(8'h22, 8'h00, 1, 0,  0, 0, 8'h22,  0, 0, 8'h22);
        add(8'h00, 8'h00, 1, 0,  1, 5, 8'h22,  1, 5, 8'h22);
        add(8'h00, 8'h00, 1, 0,  1, 5, 8'h22,  1, 5, 8'h22);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h02,  0, 0, 8'h02);
        add(8'h00, 8'h00, 1, 0,  1, 1, 8'h02,  1, 1, 8'h02);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00);
        add(8'h00, 8'h00, 1, 0,  0, 0, 8'h00,  0, 0, 8'h00);
        // round-robin vs fixed: fixed 7,7,3 ; rr 7,3,7
        add(8'h88, 8'h00, 1, 0,  0, 0, 8'h88,  0, 0, 8'h88);
        add(8'h00, 8'h00, 1, 0,  1, 7, 8'h88,  1, 7, 8'h88);
        add(8'h80, 8'h00, 1, 1,  0, 0, 8'h88,  0, 0, 8'h88);
        add(8'h00, 8'h00, 1, 0,  1, 7, 8'h88,  1, 3, 8'h88);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h08,  0, 0, 8'h80);
        add(8'h00, 8'h00, 1, 0,  1, 3, 8'h08,  1, 7, 8'h80);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00);
        add(8'h00, 8'h00, 1, 0,  0, 0, 8'h00,  0, 0, 8'h00);
        // mask: 5 masked, grant 2, unmask during grant, then 5
        add(8'h24, 8'h20, 1, 0,  0, 0, 8'h24,  0, 0, 8'h24);
        add(8'h00, 8'h20, 1, 0,  1, 2, 8'h24,  1, 2, 8'h24);
        add(8'h00, 8'h00, 1, 0,  1, 2, 8'h24,  1, 2, 8'h24);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h20,  0, 0, 8'h20);
        add(8'h00, 8'h00, 1, 0,  1, 5, 8'h20,  1, 5, 8'h20);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00);
        add(8'h00, 8'h00, 1, 0,  0, 0, 8'h00,  0, 0, 8'h00);
        // set/clear collision on line 4
        add(8'h10, 8'h00, 1, 0,  0, 0, 8'h10,  0, 0, 8'h10);
        add(8'h00, 8'h00, 1, 0,  1, 4, 8'h10,  1, 4, 8'h10);
        add(8'h10, 8'h00, 1, 1,  0, 0, 8'h10,  0, 0, 8'h10);
        add(8'h00, 8'h00, 1, 0,  1, 4, 8'h10,  1, 4, 8'h10);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00);
        // enable gating; en ignored once granted
        add(8'h40, 8'h00, 0, 0,  0, 0, 8'h40,  0, 0, 8'h40);
        add(8'h00, 8'h00, 0, 0,  0, 0, 8'h40,  0, 0, 8'h40);
        add(8'h00, 8'h00, 0, 0,  0, 0, 8'h40,  0, 0, 8'h40);
        add(8'h00, 8'h00, 1, 0,  1, 6, 8'h40,  1, 6, 8'h40);
        add(8'h00, 8'h00, 0, 0,  1, 6, 8'h40,  1, 6, 8'h40);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00);
        // ack while idle does not clear pending
        add(8'h01, 8'h00, 0, 1,  0, 0, 8'h01,  0, 0, 8'h01);
        add(8'h00, 8'h00, 0, 1,  0, 0, 8'h01,  0, 0, 8'h01);
        add(8'h00, 8'h00, 1, 0,  1, 0, 8'h01,  1, 0, 8'h01);
        add(8'h00, 8'h00, 1, 1,  0, 0, 8'h00,  0, 0, 8'h00);

        // reset held with all requests high
        rst = 1'b1; en = 1'b0; req = 8'hFF; mask = 8'h00; ack = 1'b0;
        @(negedge clk);
        chk_all("rst held", 0, 0, 8'h00, 0, 0, 8'h00);
        chk("rst fix id", 64'(bus0.id), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all("first edge", 0, 0, 8'hFF, 0, 0, 8'hFF);
        en = 1'b1;
        @(posedge clk); #1;
        chk_all("grant pre-rst", 1, 7, 8'hFF, 1, 7, 8'hFF);
        // asynchronous reset mid-cycle during GRANT
        #3 rst = 1'b1;
        #1;
        chk_all("async rst", 0, 0, 8'h00, 0, 0, 8'h00);
        chk("async rst fix id", 64'(bus0.id), 64'd0);
        chk("async rst rr id", 64'(bus1.id), 64'd0);
        req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_all($sformatf("post-rst %0d", k), 0, 0, 8'h00, 0, 0, 8'h00);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req; mask = tbl[i].mask; en = tbl[i].en; ack = tbl[i].ack;
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            chk_all($sformatf("v%0d", i), e.v0, e.id0, e.p0, e.v1, e.id1, e.p1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prio_irq_ctrl.md
# prio_irq_ctrl

Parametrised, registered priority interrupt controller. It captures rising edges on `N` request lines into a pending register and applies a per-line mask. It selects one eligible line by fixed or round-robin priority and presents its index with a valid/ack handshake. It sits between peripheral request sources and the servicing sequencer, and replaces the combinational 8-to-3 priority encoder in new designs.

## Interface
- `N`, 8: number of request lines; legal range 2..64.
- `RR`, 0: priority mode. 0 = fixed (highest index wins); 1 = round-robin.
- `W`, `$clog2(N)`: index width; derived, do not override.
- `clk`  in  1: single clock; rising-edge active.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: grant enable; while low, no new grant is issued.
- `req`  in  N: level request lines, synchronous to `clk`; only a 0→1 transition registers a request.
- `mask`  in  N: 1 = line ineligible for grant (pending bit still captured).
- `ack`  in  1: servicing side accepts the current grant.
- `valid`  out  1: `id` holds a granted line.
- `id`  out  W: index of the granted line.
- `pending`  out  N: registered pending bits.

## Operation
- Edge capture: `req_q` registers `req`; `rise = req & ~req_q`.
- Pending update: `pending <= (pending & ~clr) | rise`. `clr` is one-hot at `id` when `ack` is accepted in GRANT, else 0.
- Set wins over clear on the same bit in the same cycle.
- `eligible = pending & ~mask`.
- Selection, RR=0: highest set index of `eligible`.
- Selection, RR=1: search order is `last-1, last-2, …, 0, N-1, …, last` (mod N). `last` is the index of the most recently acked grant, so that line drops to lowest priority.
- Since `last` resets to 0, RR=1 behaves as RR=0 until the first ack.
- FSM, two states, reset to IDLE:
  - IDLE → GRANT when `en=1` and `eligible≠0`. The selected index is registered into `id` and `valid<=1`.
  - GRANT holds; `id` is frozen regardless of new requests, mask changes or `en`.
  - GRANT → IDLE on `ack=1`. `valid<=0`, `pending[id]` is cleared (unless a same-cycle rise occurs), and `last<=id` (RR=1 only).
  - `ack` in IDLE is ignored.
- A granted line that becomes masked stays granted until acked.
- `id` keeps its last value while `valid=0`. The bench must not check `id` when `valid=0`.

## Timing
- Reset values: `valid=0`, `id=0`, `pending=0`, `req_q=0`, `last=0`, state IDLE.
- All state registers clear immediately on `rst` assertion, mid-grant included.
- Because `req_q` resets to 0, a `req` bit already high at reset release is captured on the first clock edge.
- Request-to-grant latency:
  - `req` first sampled high at edge k → `pending` bit set after edge k.
  - `valid=1` after edge k+1 (2 cycles), provided the FSM is in IDLE, `en=1` and the line is selected.
- Ack sampled at edge e → `valid=0` and pending bit cleared after edge e.
- Next grant earliest after edge e+1. `valid` is low for exactly one cycle between back-to-back grants.
- `pending` output is the register value, with no combinational path from `req`.
- Outputs are registered; there is no combinational path from any input to `valid` or `id`.

## Test plan
- Reset: assert `rst` mid-cycle with `req=8'hFF` → `valid=0`, `id=0`, `pending=0` asynchronously. After release, with `req` held at FF, `pending=8'hFF` after the first edge.
- Fixed priority (N=8, RR=0): one-cycle pulse on `req[1]` and `req[5]` together.
  - `valid=1`, `id=5` two cycles later.
  - Ack → one cycle `valid=0` → `valid=1`, `id=1`.
  - Ack → `valid=0`, `pending=0`.
- Round-robin (N=8, RR=1): pulse bits 7 and 3 → `id=7`. Pulse bit 7 again, then ack → next `id=3`, then `id=7`. The same stimulus with RR=0 gives 7, 7, 3.
- Mask: `mask=8'h20`, pulse bits 5 and 2 → `id=2`. Clear the mask during GRANT → `id` stays 2. After ack → `id=5`.
- Set/clear collision: grant on `id=4`; ack in the same cycle as a new rise on `req[4]` → `pending[4]=1`, then re-grant `id=4` after the one-cycle gap.
- Enable/reset: `en=0` with pending bits → `valid` stays 0.
  - `en=1` → grant two cycles after pending was set... more precisely, one cycle after `en` rises.
  - Assert `rst` during GRANT → `valid=0` and `pending=0` immediately; no grant after release until a new request rise.
